// File: rtl/ctrl_status_regs_n_pkg.sv
// Shared register map and bit positions for the control/status register block.
package ctrl_status_regs_n_pkg;

    // Register indices
    localparam int CTRL_IDX   = 0;
    localparam int STATUS_IDX = 1;
    localparam int CFG_BASE   = 2;

    // CTRL bit positions
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_SRST_BIT  = 1;
    localparam int CTRL_IRQEN_BIT = 2;

    // STATUS bit positions; the sticky bits are contiguous starting at done_st
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_OVF_BIT  = 2;
    localparam int STAT_ERR_BIT  = 3;

    // Sticky bit slots, in STATUS bit order
    typedef enum int {
        STICKY_DONE = 0,
        STICKY_OVF  = 1,
        STICKY_ERR  = 2
    } sticky_idx_e;

    localparam int NSTICKY = 3;

    // STATUS bit position of sticky slot i
    function automatic int sticky_bit_pos(input int i);
        return STAT_DONE_BIT + i;
    endfunction

endpackage

// File: rtl/ctrl_status_regs_n_sticky_w1c_bit.sv
// One sticky status bit: set by an event, cleared by write-1 or a bulk clear.
// A set in the same cycle as either clear wins, so no event is ever lost.
module sticky_w1c_bit (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    input  logic clear_all,
    output logic q
);

    logic q_q;
    logic q_d;

    // Next value: set dominates any clear
    always_comb begin
        q_d = q_q;
        if (set) begin
            q_d = 1'b1;
        end else if (clr || clear_all) begin
            q_d = 1'b0;
        end
    end

    // State flop with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ctrl_status_regs_n.sv
// Control/status register bank: CTRL, STATUS and NREGS-2 config words with
// shadow copies that are captured on an accepted start and held while busy.
module ctrl_status_regs_n
    import ctrl_status_regs_n_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 8,
    parameter int AWIDTH = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [AWIDTH-1:0]            addr,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [DWIDTH-1:0]            data_in,
    output logic [DWIDTH-1:0]            data_out,
    output logic                         start,
    output logic                         soft_reset,
    output logic [(NREGS-2)*DWIDTH-1:0]  cfg,
    output logic                         irq,
    input  logic                         done,
    input  logic                         accum_ovrflow
);

    localparam int NCFG = NREGS - 2;

    int                       addr_i;
    logic                     wr_ctrl;
    logic                     wr_status;
    logic                     start_req;
    logic                     srst_req;
    logic                     start_ok;
    logic                     start_bad;
    logic [NSTICKY-1:0]       st_set;
    logic [NSTICKY-1:0]       st_clr;
    logic [NSTICKY-1:0]       st_q;
    logic [NCFG*DWIDTH-1:0]   live_flat;
    logic [DWIDTH-1:0]        rd_val;

    logic busy_q, busy_d;
    logic start_q, start_d;
    logic soft_reset_q, soft_reset_d;
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;
    logic [DWIDTH-1:0] data_out_q, data_out_d;

    assign addr_i = int'(addr);

    // Decode CTRL/STATUS writes; soft_reset in the same write masks start
    always_comb begin
        wr_ctrl   = wr_en && (addr_i == CTRL_IDX);
        wr_status = wr_en && (addr_i == STATUS_IDX);
        srst_req  = wr_ctrl && data_in[CTRL_SRST_BIT];
        start_req = wr_ctrl && data_in[CTRL_START_BIT] && !data_in[CTRL_SRST_BIT];
        start_ok  = start_req && !busy_q;
        start_bad = start_req && busy_q;
    end

    // Sticky set/clear sources, one per STATUS sticky bit
    always_comb begin
        st_set[STICKY_DONE] = done;
        st_set[STICKY_OVF]  = accum_ovrflow;
        st_set[STICKY_ERR]  = start_bad;
        for (int i = 0; i < NSTICKY; i++) begin
            st_clr[i] = wr_status && data_in[sticky_bit_pos(i)];
        end
    end

    for (genvar gi = 0; gi < NSTICKY; gi++) begin : g_sticky
        sticky_w1c_bit u_bit (
            .clk       (clk),
            .reset     (reset),
            .set       (st_set[gi]),
            .clr       (st_clr[gi]),
            .clear_all (srst_req),
            .q         (st_q[gi])
        );
    end

    // Live copy follows bus writes; shadow snapshots all live words on an accepted start
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        logic [DWIDTH-1:0] live_q, live_d;
        logic [DWIDTH-1:0] shadow_q, shadow_d;

        // Next live/shadow values for this word
        always_comb begin
            live_d   = live_q;
            shadow_d = shadow_q;
            if (wr_en && (addr_i == CFG_BASE + gi)) begin
                live_d = data_in;
            end
            if (start_ok) begin
                shadow_d = live_q;
            end
        end

        // Live and shadow word flops
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                live_q   <= '0;
                shadow_q <= '0;
            end else begin
                live_q   <= live_d;
                shadow_q <= shadow_d;
            end
        end

        assign live_flat[gi*DWIDTH +: DWIDTH] = live_q;
        assign cfg[gi*DWIDTH +: DWIDTH]       = shadow_q;
    end

    // Control state: busy tracking, pulses, irq enable and registered irq
    always_comb begin
        busy_d       = busy_q;
        irq_en_d     = irq_en_q;
        start_d      = start_ok;
        soft_reset_d = srst_req;
        if (srst_req) begin
            busy_d = 1'b0;
        end else if (start_ok) begin
            busy_d = 1'b1;
        end else if (done) begin
            busy_d = 1'b0;
        end
        if (wr_ctrl) begin
            irq_en_d = data_in[CTRL_IRQEN_BIT];
        end
        irq_d = irq_en_q && (|st_q);
    end

    // Read mux: CFG reads return the live copy; unmapped addresses read 0
    always_comb begin
        rd_val = '0;
        if (addr_i == CTRL_IDX) begin
            rd_val[CTRL_IRQEN_BIT] = irq_en_q;
        end else if (addr_i == STATUS_IDX) begin
            rd_val[STAT_BUSY_BIT] = busy_q;
            for (int i = 0; i < NSTICKY; i++) begin
                rd_val[sticky_bit_pos(i)] = st_q[i];
            end
        end else begin
            for (int k = 0; k < NCFG; k++) begin
                if (addr_i == CFG_BASE + k) begin
                    rd_val = live_flat[k*DWIDTH +: DWIDTH];
                end
            end
        end
        data_out_d = rd_en ? rd_val : data_out_q;
    end

    // Control and read-data flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            soft_reset_q <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_q        <= 1'b0;
            data_out_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            start_q      <= start_d;
            soft_reset_q <= soft_reset_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
            data_out_q   <= data_out_d;
        end
    end

    assign start      = start_q;
    assign soft_reset = soft_reset_q;
    assign irq        = irq_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_ctrl_status_regs_n.sv
// Directed bench for ctrl_status_regs_n: a register access table plus
// hand-written multi-cycle sequences for start/busy/irq/soft-reset behaviour.
module tb_ctrl_status_regs_n;

    localparam int DW = 32;
    localparam int NR = 6;
    localparam int AW = 3;

    logic              clk;
    logic              reset;
    logic [AW-1:0]     addr;
    logic              wr_en;
    logic              rd_en;
    logic [DW-1:0]     data_in;
    logic [DW-1:0]     data_out;
    logic              start;
    logic              soft_reset;
    logic [(NR-2)*DW-1:0] cfg;
    logic              irq;
    logic              done;
    logic              accum_ovrflow;

    int total = 0;
    int bad   = 0;

    ctrl_status_regs_n #(.DWIDTH(DW), .NREGS(NR), .AWIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .data_in       (data_in),
        .data_out      (data_out),
        .start         (start),
        .soft_reset    (soft_reset),
        .cfg           (cfg),
        .irq           (irq),
        .done          (done),
        .accum_ovrflow (accum_ovrflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        int          a;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cfg_word(input int k);
        return cfg[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        addr = AW'(a); data_in = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        $display("wr addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string name);
        addr = AW'(a); rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        $display("rd addr=%0d data=0x%08h exp=0x%08h", a, data_out, exp);
        check(name, {32'h0, data_out}, {32'h0, exp});
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        $display("done pulse");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 0, 32'h0,        32'h0,        "reset_ctrl"};
        vecs[1]  = '{1'b0, 1, 32'h0,        32'h0,        "reset_status"};
        vecs[2]  = '{1'b1, 2, 32'hDEADBEEF, 32'h0,        "wr_cfg0"};
        vecs[3]  = '{1'b0, 2, 32'h0,        32'hDEADBEEF, "rd_cfg0"};
        vecs[4]  = '{1'b1, 5, 32'h12345678, 32'h0,        "wr_cfg3"};
        vecs[5]  = '{1'b0, 5, 32'h0,        32'h12345678, "rd_cfg3"};
        vecs[6]  = '{1'b1, 6, 32'hAAAA5555, 32'h0,        "wr_oor"};
        vecs[7]  = '{1'b0, 6, 32'h0,        32'h0,        "rd_oor6"};
        vecs[8]  = '{1'b0, 7, 32'h0,        32'h0,        "rd_oor7"};
        vecs[9]  = '{1'b1, 0, 32'hFFFFFFF4, 32'h0,        "wr_ctrl_en"};
        vecs[10] = '{1'b0, 0, 32'h0,        32'h4,        "rd_ctrl_en"};
        vecs[11] = '{1'b1, 1, 32'hFFFFFFFF, 32'h0,        "wr_status_ones"};
        vecs[12] = '{1'b0, 1, 32'h0,        32'h0,        "rd_status_idle"};
        vecs[13] = '{1'b1, 0, 32'h0,        32'h0,        "wr_ctrl_zero"};
        vecs[14] = '{1'b0, 0, 32'h0,        32'h0,        "rd_ctrl_zero"};
        vecs[15] = '{1'b0, 2, 32'h0,        32'hDEADBEEF, "rd_cfg0_again"};

        reset = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        done = 1'b0; accum_ovrflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", {32'h0, data_out}, 64'h0);
        check("reset_start", {63'h0, start}, 64'h0);
        check("reset_irq", {63'h0, irq}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_reset_start", {63'h0, start}, 64'h0);
        check("post_reset_soft", {63'h0, soft_reset}, 64'h0);

        // Register access table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) wr(vecs[i].a, vecs[i].d);
            else rd(vecs[i].a, vecs[i].exp, vecs[i].name);
        end

        // data_out holds while rd_en is low
        addr = AW'(5);
        tick();
        check("rd_hold", {32'h0, data_out}, {32'h0, 32'hDEADBEEF});

        // Start with busy=0: pulse, busy, shadow capture
        wr(2, 32'h0000_1234);
        check("no_start_yet", {63'h0, start}, 64'h0);
        wr(0, 32'h1);
        check("start_pulse", {63'h0, start}, 64'h1);
        check("cfg0_shadow", {32'h0, cfg_word(0)}, {32'h0, 32'h1234});
        check("cfg3_shadow", {32'h0, cfg_word(3)}, {32'h0, 32'h12345678});
        rd(1, 32'h1, "status_busy");
        check("start_one_cycle", {63'h0, start}, 64'h0);

        // Live write while busy leaves shadow alone
        wr(2, 32'h0000_FFFF);
        check("cfg0_stable", {32'h0, cfg_word(0)}, {32'h0, 32'h1234});
        rd(2, 32'hFFFF, "rd_cfg0_live");

        // Start while busy is rejected
        wr(0, 32'h1);
        check("reject_no_start", {63'h0, start}, 64'h0);
        rd(1, 32'h9, "status_err");
        check("reject_cfg0", {32'h0, cfg_word(0)}, {32'h0, 32'h1234});

        // Done with irq enabled, then W1C, then done vs W1C collision
        wr(1, 32'h8);
        wr(0, 32'h4);
        pulse_done();
        rd(1, 32'h2, "status_done");
        check("irq_set", {63'h0, irq}, 64'h1);
        wr(1, 32'h2);
        rd(1, 32'h0, "status_w1c");
        check("irq_clear", {63'h0, irq}, 64'h0);
        addr = AW'(1); data_in = 32'h2; wr_en = 1'b1; done = 1'b1;
        tick();
        wr_en = 1'b0; done = 1'b0;
        $display("wr addr=1 data=0x00000002 with done");
        rd(1, 32'h2, "set_beats_w1c");
        accum_ovrflow = 1'b1;
        tick();
        accum_ovrflow = 1'b0;
        $display("ovf pulse");
        rd(1, 32'h6, "status_ovf");

        // Start accepted, then start+done collision while busy
        wr(1, 32'hE);
        wr(0, 32'h5);
        check("start2_pulse", {63'h0, start}, 64'h1);
        check("cfg0_recapture", {32'h0, cfg_word(0)}, {32'h0, 32'hFFFF});
        addr = AW'(0); data_in = 32'h5; wr_en = 1'b1; done = 1'b1;
        tick();
        wr_en = 1'b0; done = 1'b0;
        $display("wr addr=0 data=0x00000005 with done");
        check("collide_no_start", {63'h0, start}, 64'h0);
        rd(1, 32'hA, "status_collide");

        // Soft reset wins over start, clears status, keeps cfg and irq_en
        wr(0, 32'h5);
        check("start3_pulse", {63'h0, start}, 64'h1);
        wr(0, 32'h7);
        check("soft_pulse", {63'h0, soft_reset}, 64'h1);
        check("soft_no_start", {63'h0, start}, 64'h0);
        rd(1, 32'h0, "status_after_soft");
        check("soft_one_cycle", {63'h0, soft_reset}, 64'h0);
        rd(0, 32'h4, "irq_en_kept");
        rd(2, 32'hFFFF, "cfg0_live_kept");
        check("cfg0_shadow_kept", {32'h0, cfg_word(0)}, {32'h0, 32'hFFFF});
        check("irq_after_soft", {63'h0, irq}, 64'h0);

        // Read-before-write on the same address
        wr(3, 32'hA5A5);
        addr = AW'(3); data_in = 32'h5A5A; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        $display("rd+wr addr=3 data_out=0x%08h", data_out);
        check("rbw_old", {32'h0, data_out}, {32'h0, 32'hA5A5});
        rd(3, 32'h5A5A, "rbw_new");

        // Asynchronous reset in the middle of busy
        wr(0, 32'h5);
        wr(0, 32'h5);
        rd(2, 32'hFFFF, "pre_reset_rd");
        check("pre_reset_irq", {63'h0, irq}, 64'h1);
        check("pre_reset_cfg1", {32'h0, cfg_word(1)}, {32'h0, 32'h5A5A});
        #2;
        reset = 1'b0;
        #1;
        $display("async reset asserted");
        check("arst_data_out", {32'h0, data_out}, 64'h0);
        check("arst_irq", {63'h0, irq}, 64'h0);
        check("arst_start", {63'h0, start}, 64'h0);
        check("arst_soft", {63'h0, soft_reset}, 64'h0);
        check("arst_cfg", {63'h0, |cfg}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("rel_start", {63'h0, start}, 64'h0);
        check("rel_soft", {63'h0, soft_reset}, 64'h0);
        rd(1, 32'h0, "rel_status");
        rd(0, 32'h0, "rel_ctrl");
        rd(2, 32'h0, "rel_cfg0");
        rd(NR, 32'h0, "rd_addr_nregs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_status_regs_n.md
CTRL_STATUS_REGS_N -- requirements
Module: ctrl_status_regs_n

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, register and bus data width (minimum 8).
REQ-002 SHALL have parameter NREGS, default 8, total register count including CTRL and STATUS (minimum 3).
REQ-003 SHALL have parameter AWIDTH, default $clog2(NREGS), address width.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port addr  in  AWIDTH  register index.
REQ-007 SHALL have port wr_en  in  1  write strobe; data_in is written to addr.
REQ-008 SHALL have port rd_en  in  1  read strobe.
REQ-009 SHALL have port data_in  in  DWIDTH  write data.
REQ-010 SHALL have port data_out  out  DWIDTH  registered read data.
REQ-011 SHALL have port start  out  1  one-cycle start pulse to the core.
REQ-012 SHALL have port soft_reset  out  1  one-cycle core reset pulse.
REQ-013 SHALL have port cfg  out  (NREGS-2)*DWIDTH  shadowed config words; word k is at bits [k*DWIDTH +: DWIDTH].
REQ-014 SHALL have port irq  out  1  level interrupt.
REQ-015 SHALL have port done  in  1  one-cycle completion pulse from the core.
REQ-016 SHALL have port accum_ovrflow  in  1  one-cycle overflow pulse from the core.

Function
REQ-017 SHALL use this map: 0 CTRL, 1 STATUS, 2..NREGS-1 CFG0..CFG(NREGS-3).
REQ-018 SHALL define CTRL as: bit0 start (write-1 pulse, reads 0); bit1 soft_reset (write-1 pulse, reads 0); bit2 irq_en (RW); all other bits read 0.
REQ-019 SHALL define STATUS as: bit0 busy (RO); bit1 done_st, bit2 ovf_st, bit3 start_err (each sticky, write-1-to-clear); all other bits read 0; writing 0 to a bit has no effect on it.
REQ-020 SHALL make CFG registers RW live copies; a write updates the live copy the next cycle, regardless of busy.
REQ-021 SHALL, for a start write with busy=0, assert start for exactly the following cycle, set busy, and copy all live CFG values into the shadow in that same edge.
REQ-022 SHALL, for a start write with busy=1, leave the start and shadow outputs unchanged and set start_err.
REQ-023 SHALL drive cfg from the shadow only, so it is stable throughout busy.
REQ-024 SHALL, on done=1, clear busy and set done_st; accum_ovrflow=1 SHALL set ovf_st.
REQ-025 SHALL resolve simultaneous events as follows:
- set beats W1C on the same bit and cycle;
- a start write with done in the same cycle while busy=1 is rejected (start_err=1, busy->0).
REQ-026 SHALL make a soft_reset write pulse soft_reset for one cycle and clear busy, done_st, ovf_st and start_err; live, shadow and irq_en are kept.
REQ-027 SHALL, when a CTRL write has start and soft_reset both 1, give soft_reset priority and ignore start.
REQ-028 SHALL load data_out one cycle after rd_en with the addressed value, and hold it while rd_en=0.
REQ-029 SHALL make reads of CFG return the live copy, not the shadow.
REQ-030 SHALL make addresses >= NREGS read 0, and writes to them have no effect.
REQ-031 SHALL define irq = irq_en & (done_st | ovf_st | start_err), registered.
REQ-032 SHALL process a simultaneous wr_en and rd_en to the same address in the same cycle with read-before-write (old value returned).

Reset
REQ-033 SHALL, on reset low, asynchronously clear all registers: data_out, start, soft_reset, irq, busy, all sticky bits, irq_en, live and shadow to 0.
REQ-034 SHALL make reset deassertion take effect on the next clk edge, with no pulse generated by reset itself.

Structure
REQ-035 SHALL place register indices (CTRL=0, STATUS=1, CFG_BASE=2) and CTRL/STATUS bit positions in the shared package.
REQ-036 SHALL implement each sticky W1C bit with one sub-module, sticky_w1c_bit (inputs set, clr, clear_all; set has priority).

Verification
REQ-037 SHALL cover: write CFG0=0x0000_1234, write CTRL=0x1 -> start high one cycle later for 1 cycle, busy=1, cfg word0=0x1234.
REQ-038 SHALL cover: while busy, write CFG0=0xFFFF -> cfg word0 stays 0x1234; a read of CFG0 returns 0xFFFF.
REQ-039 SHALL cover: CTRL=0x1 while busy -> no start pulse, STATUS reads 0x9.
REQ-040 SHALL cover: irq_en=1, done pulse -> busy=0, STATUS=0x2, irq=1; write STATUS=0x2 -> STATUS=0x0, irq=0; done and W1C in the same cycle -> done_st stays 1.
REQ-041 SHALL cover: CTRL=0x3 -> soft_reset pulse, no start, stickies cleared, CFG values retained.
REQ-042 SHALL cover: reset asserted mid-busy -> all outputs 0 immediately; read of addr NREGS -> 0.
